// File: rtl/average_filter_mc_pkg.sv
// Shared widths and constant helpers for the multi-channel window averaging filter.
package average_filter_mc_pkg;

  typedef enum logic {
    MODE_AVG    = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_e;

  // Width that holds the sum of n pixels of pix_w bits without overflow.
  function automatic int sum_width(input int pix_w, input int n);
    return pix_w + $clog2(n);
  endfunction

  // Adder tree, divide register and output register.
  function automatic int pipe_depth(input int n);
    return $clog2(n) + 2;
  endfunction

  // Every reachable dividend is below 2**sum_w, so a shift of sum_w + clog2(n)
  // keeps x * (ceil(2**k / n) * n - 2**k) below 2**k, which makes the
  // reciprocal product floor-exact.
  function automatic int recip_shift(input int n, input int sum_w);
    return sum_w + $clog2(n);
  endfunction

  function automatic longint recip_const(input int n, input int sum_w);
    longint pow2;
    pow2 = longint'(1) << recip_shift(n, sum_w);
    return (pow2 + longint'(n) - 1) / longint'(n);
  endfunction

endpackage

// File: rtl/avg_recip_div.sv
// One-channel divide-by-window-size stage via reciprocal multiply, plus centre-pixel bypass.
// Rounding: define AVERAGE_FILTER_MC_ROUND_EN for round-half-up, otherwise truncation.
module avg_recip_div
  import average_filter_mc_pkg::*;
#(
  parameter int PIX_DATA_W    = 12,
  parameter int INPUTS_AMOUNT = 9,
  parameter int SUM_W         = sum_width(PIX_DATA_W, INPUTS_AMOUNT)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [SUM_W-1:0]      sum_i,
  input  logic [PIX_DATA_W-1:0] center_i,
  output logic [PIX_DATA_W-1:0] res_o
);

  localparam int SHIFT  = recip_shift(INPUTS_AMOUNT, SUM_W);
  localparam int COEF_W = SUM_W + 1;
  localparam int PROD_W = SHIFT + PIX_DATA_W;
  localparam logic [COEF_W-1:0] RECIP = COEF_W'(recip_const(INPUTS_AMOUNT, SUM_W));

`ifdef AVERAGE_FILTER_MC_ROUND_EN
  localparam logic [SUM_W-1:0] BIAS = SUM_W'(INPUTS_AMOUNT / 2);

  // Largest sum plus bias is still below 2**SUM_W, so no carry is lost.
  function automatic logic [SUM_W-1:0] add_bias(input logic [SUM_W-1:0] x);
    return x + BIAS;
  endfunction
`else
  function automatic logic [SUM_W-1:0] add_bias(input logic [SUM_W-1:0] x);
    return x;
  endfunction
`endif

  // The quotient never exceeds the pixel range, so PROD_W bits hold the product.
  function automatic logic [PIX_DATA_W-1:0] recip_scale(input logic [SUM_W-1:0] x);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(x) * PROD_W'(RECIP);
    return PIX_DATA_W'(prod >> SHIFT);
  endfunction

  logic [PIX_DATA_W-1:0] quot;

  always_comb begin
    quot = recip_scale(add_bias(sum_i));
  end

  // divide stage register
  always_ff @(posedge clk_i) begin
    if (en_i) res_o <= (mode_i == MODE_BYPASS) ? center_i : quot;
  end

endmodule

// File: rtl/pipeline_adder.sv
// Registered binary adder tree summing N unsigned inputs; every level advances on en_i.
module pipeline_adder #(
  parameter int IN_W   = 12,
  parameter int N      = 9,
  parameter int OUT_W  = IN_W + $clog2(N),
  parameter int STAGES = $clog2(N)
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [N-1:0][IN_W-1:0]   data_i,
  output logic [OUT_W-1:0]         sum_o
);

  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int CNT_IN  = (N + (1 << s) - 1) >> s;
    localparam int CNT_OUT = (CNT_IN + 1) / 2;

    logic [OUT_W-1:0] in_w  [CNT_IN];
    logic [OUT_W-1:0] sum_q [CNT_OUT];

    if (s == 0) begin : g_src
      for (genvar i = 0; i < CNT_IN; i++) begin : g_i
        assign in_w[i] = OUT_W'(data_i[i]);
      end
    end else begin : g_src
      for (genvar i = 0; i < CNT_IN; i++) begin : g_i
        assign in_w[i] = g_lvl[s-1].sum_q[i];
      end
    end

    // An odd element at the end of a level is carried forward unchanged.
    for (genvar i = 0; i < CNT_OUT; i++) begin : g_node
      if (2 * i + 1 < CNT_IN) begin : g_pair
        always_ff @(posedge clk_i) begin
          if (en_i) sum_q[i] <= in_w[2*i] + in_w[2*i+1];
        end
      end else begin : g_pass
        always_ff @(posedge clk_i) begin
          if (en_i) sum_q[i] <= in_w[2*i];
        end
      end
    end
  end

  assign sum_o = g_lvl[STAGES-1].sum_q[0];

endmodule

// File: rtl/average_filter_mc.sv
// Multi-channel WINDOW_SIZE x WINDOW_SIZE averaging filter with valid/ready flow control.
// Rounding: define AVERAGE_FILTER_MC_ROUND_EN for round-half-up, otherwise truncation.
module average_filter_mc
  import average_filter_mc_pkg::*;
#(
  parameter int PIX_DATA_W    = 12,
  parameter int WINDOW_SIZE   = 3,
  parameter int CHANNELS      = 2,
  parameter int INPUTS_AMOUNT = WINDOW_SIZE ** 2
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  mode_i,
  input  logic                                                  data_valid_i,
  output logic                                                  data_ready_o,
  input  logic [CHANNELS-1:0][INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] data_i,
  output logic                                                  data_valid_o,
  input  logic                                                  data_ready_i,
  output logic [CHANNELS-1:0][PIX_DATA_W-1:0]                   data_o
);

  localparam int SUM_W       = sum_width(PIX_DATA_W, INPUTS_AMOUNT);
  localparam int TREE_STAGES = pipe_depth(INPUTS_AMOUNT) - 2;
  localparam int CENTER      = INPUTS_AMOUNT / 2;

  logic                                  adv;
  logic                                  vld_p  [TREE_STAGES];
  logic                                  mode_p [TREE_STAGES];
  logic [CHANNELS-1:0][PIX_DATA_W-1:0]   ctr_p  [TREE_STAGES];
  logic [CHANNELS-1:0][SUM_W-1:0]        sum_tree;
  logic                                  div_vld_p;
  logic [CHANNELS-1:0][PIX_DATA_W-1:0]   div_res_p;

  // One enable freezes every stage while a result waits for the consumer.
  assign adv          = !data_valid_o || data_ready_i;
  assign data_ready_o = adv;

  // adder tree stages: valid bits
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int s = 0; s < TREE_STAGES; s++) vld_p[s] <= 1'b0;
      div_vld_p    <= 1'b0;
      data_valid_o <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= data_valid_i;
      for (int s = 1; s < TREE_STAGES; s++) vld_p[s] <= vld_p[s-1];
      div_vld_p    <= vld_p[TREE_STAGES-1];
      data_valid_o <= div_vld_p;
    end
  end

  // adder tree stages: mode and centre pixel travel beside the sums
  always_ff @(posedge clk_i) begin
    if (adv) begin
      mode_p[0] <= mode_i;
      for (int ch = 0; ch < CHANNELS; ch++) ctr_p[0][ch] <= data_i[ch][CENTER];
      for (int s = 1; s < TREE_STAGES; s++) begin
        mode_p[s] <= mode_p[s-1];
        ctr_p[s]  <= ctr_p[s-1];
      end
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    pipeline_adder #(
      .IN_W   (PIX_DATA_W),
      .N      (INPUTS_AMOUNT),
      .OUT_W  (SUM_W),
      .STAGES (TREE_STAGES)
    ) u_sum (
      .clk_i  (clk_i),
      .en_i   (adv),
      .data_i (data_i[ch]),
      .sum_o  (sum_tree[ch])
    );

    avg_recip_div #(
      .PIX_DATA_W    (PIX_DATA_W),
      .INPUTS_AMOUNT (INPUTS_AMOUNT),
      .SUM_W         (SUM_W)
    ) u_div (
      .clk_i    (clk_i),
      .en_i     (adv),
      .mode_i   (mode_p[TREE_STAGES-1]),
      .sum_i    (sum_tree[ch]),
      .center_i (ctr_p[TREE_STAGES-1][ch]),
      .res_o    (div_res_p[ch])
    );
  end

  // output register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_o <= '0;
    end else if (adv) begin
      data_o <= div_res_p;
    end
  end

endmodule

// File: tb/tb_average_filter_mc.sv
// Directed bench for average_filter_mc with a scoreboard queue and a negedge output monitor.
module tb_average_filter_mc;

  localparam int P   = 12;
  localparam int WS  = 3;
  localparam int CH  = 2;
  localparam int N   = WS * WS;
  localparam int LAT = 6;
  localparam int CTR = N / 2;
`ifdef AVERAGE_FILTER_MC_ROUND_EN
  localparam int BIAS = N / 2;
`else
  localparam int BIAS = 0;
`endif
  localparam logic [P-1:0] EXP14 = (BIAS != 0) ? 12'd2 : 12'd1;

  typedef logic [CH-1:0][N-1:0][P-1:0] win_t;
  typedef logic [CH-1:0][P-1:0]        res_t;

  logic clk          = 1'b0;
  logic rst_i        = 1'b0;
  logic mode_i       = 1'b0;
  logic data_valid_i = 1'b0;
  logic data_ready_i = 1'b1;
  win_t data_i       = '0;
  logic data_ready_o;
  logic data_valid_o;
  res_t data_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  res_t sb[$];

  average_filter_mc #(
    .PIX_DATA_W  (P),
    .WINDOW_SIZE (WS),
    .CHANNELS    (CH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mode_i       (mode_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic m, input win_t w);
    res_t r;
    int   sum;
    for (int c = 0; c < CH; c++) begin
      sum = 0;
      for (int k = 0; k < N; k++) sum += int'(w[c][k]);
      r[c] = m ? w[c][CTR] : P'((sum + BIAS) / N);
    end
    return r;
  endfunction

  function automatic win_t fill(input logic [P-1:0] v);
    win_t w;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < N; k++) w[c][k] = v;
    return w;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < N; k++) w[c][k] = P'($urandom_range(0, 4095));
    return w;
  endfunction

  // Holds the window until accepted; leaves data_valid_i high for back-to-back use.
  task automatic send(input logic m, input win_t w, input res_t exp, output int t_acc);
    logic ok;
    mode_i = m;
    data_i = w;
    data_valid_i = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = data_ready_o;
      @(posedge clk);
      #1;
      if (ok) begin
        t_acc = cyc - 1;
        sb.push_back(exp);
        break;
      end
    end
    check("accept", 32'(t_acc >= 0), 32'd1);
  endtask

  task automatic check_latency(input int t_acc);
    data_valid_i = 1'b0;
    for (int i = 0; i < 20 && !data_valid_o; i++) begin
      @(posedge clk);
      #1;
    end
    check("latency", 32'(cyc - t_acc), 32'(LAT));
  endtask

  task automatic drain();
    data_valid_i = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: consumes scoreboard entries and checks hold-during-stall.
  logic prev_stall = 1'b0;
  res_t prev_data  = '0;
  always @(negedge clk) begin
    res_t exp;
    if (rst_i) begin
      if (prev_stall) begin
        check("stall_valid", 32'(data_valid_o), 32'd1);
        check("stall_data", 32'(data_o), 32'(prev_data));
      end
      if (data_valid_o && data_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(data_valid_o), 32'd0);
        end else begin
          exp = sb.pop_front();
          check("data_o", 32'(data_o), 32'(exp));
        end
      end
      prev_stall <= data_valid_o && !data_ready_i;
      prev_data  <= data_o;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    int   t;
    win_t w;
    res_t e;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ready", 32'(data_ready_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    // all pixels 9, latency
    e[0] = 12'd9; e[1] = 12'd9;
    send(1'b0, fill(12'd9), e, t);
    check_latency(t);
    drain();

    // full scale
    e[0] = 12'd4095; e[1] = 12'd4095;
    send(1'b0, fill(12'd4095), e, t);
    drain();

    // rounding boundary: ch0 SUM=14, ch1 SUM=13
    w = '0;
    w[0][0] = 12'd14;
    w[1][1] = 12'd6;
    w[1][7] = 12'd7;
    e[0] = EXP14; e[1] = 12'd1;
    send(1'b0, w, e, t);
    drain();

    // 10-window stream with a 3-cycle downstream stall
    for (int i = 0; i < 7; i++) begin
      w = rand_win();
      send(1'b0, w, model(1'b0, w), t);
    end
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 32'(data_ready_o), 32'd0);
      @(posedge clk);
      #1;
    end
    data_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = rand_win();
      send(1'b0, w, model(1'b0, w), t);
    end
    drain();

    // mode toggling per sample
    w = '0;
    w[0][CTR] = 12'd100;
    w[1][CTR] = 12'd100;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        e[0] = 12'd100; e[1] = 12'd100;
      end else begin
        e[0] = 12'd11; e[1] = 12'd11;
      end
      send(1'(i % 2), w, e, t);
    end
    drain();

    // reset with 4 samples in flight
    for (int i = 0; i < 4; i++) begin
      w = rand_win();
      send(1'b0, w, model(1'b0, w), t);
    end
    data_valid_i = 1'b0;
    rst_i = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    check("rst_mid_valid", 32'(data_valid_o), 32'd0);
    check("rst_mid_ready", 32'(data_ready_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("no_stale", 32'(data_valid_o), 32'd0);
    end

    // pipeline usable after reset
    w = rand_win();
    send(1'b1, w, model(1'b1, w), t);
    check_latency(t);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
